// File: rtl/serial_adder_ctrl_if.sv
// Handshake/data bundle between an operand source and the serial adder.
// The source drives start and the operands; the adder returns status and result.
interface serial_adder_ctrl_if #(
  parameter int W = 8
) ();
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, op_a, op_b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder. Operands are latched on an accepted start and
// shifted LSB-first through a full-adder cell built from two half adders.
// The running carry lives in a flop; the sum is assembled MSB-in in a
// shift register and completion is flagged with a one-cycle done pulse.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// state | meaning
// IDLE  | waiting for start; result outputs hold the last sum/cout
// SHIFT | W edges of bit-serial add, then one terminal-count cycle
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam int            CW       = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W);
  localparam logic [CW-1:0] CNT_PEN  = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          load;
  logic          shift;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  sum_sr;
  logic [W-1:0]  s_msb;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;
  logic          s1;
  logic          c1;
  logic          s_bit;
  logic          c2;
  logic          carry_nxt;

  half_adder u_ha1 (.a(a_sr[0]), .b(b_sr[0]), .s(s1),    .c(c1));
  half_adder u_ha2 (.a(s1),      .b(carry),   .s(s_bit), .c(c2));

  assign carry_nxt = c1 | c2;

  // Place the new sum bit at the MSB position; written this way so W=1 needs no special slice.
  always_comb begin
    s_msb        = '0;
    s_msb[W-1]   = s_bit;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath enables. The cycle after the W-th shift edge
  // is the terminal-count cycle: no shift, just the move to DONE.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end else begin
          shift = 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, carry flop, bit counter and sum assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (load) begin
      a_sr   <= bus.op_a;
      b_sr   <= bus.op_b;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (shift) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= (sum_sr >> 1) | s_msb;
      cnt    <= cnt + 1'b1;
      carry  <= carry_nxt;
      if (cnt == CNT_PEN) begin
        cout_q <= carry_nxt;
      end
    end
  end

  // Status flags registered from the next state so outputs come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == SHIFT);
      done_q <= (state_nxt == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_sr;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a W=8 and a W=1 instance,
// table vectors, hand-written corner sequences and random operands checked
// against a plain-arithmetic reference.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  serial_adder_ctrl_if #(.W(8)) if8 ();
  serial_adder_ctrl_if #(.W(1)) if1 ();

  serial_adder_ctrl #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder_ctrl #(.W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic c;
  } vec1_t;

  vec8_t v8[8];
  vec1_t v1[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one W=8 addition from an idle adder; checks latency, busy length,
  // result, and that done drops next cycle while the result holds.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] es, input logic ec, input string tag);
    int lat;
    int bc;
    @(negedge clk);
    if8.start = 1'b1;
    if8.op_a  = a;
    if8.op_b  = b;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 0;
    bc  = 0;
    while (!if8.done && lat < 40) begin
      if (if8.busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, bc, 9);
    check({tag, "_busy_at_done"}, {31'd0, if8.busy}, 0);
    check({tag, "_sum"}, {24'd0, if8.sum}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, if8.cout}, {31'd0, ec});
    @(posedge clk); #1;
    check({tag, "_done_fall"}, {31'd0, if8.done}, 0);
    check({tag, "_sum_hold"}, {24'd0, if8.sum}, {24'd0, es});
  endtask

  task automatic op1(input logic a, input logic b, input logic es, input logic ec,
                     input string tag);
    int lat;
    int bc;
    @(negedge clk);
    if1.start = 1'b1;
    if1.op_a  = a;
    if1.op_b  = b;
    @(posedge clk); #1;
    if1.start = 1'b0;
    lat = 0;
    bc  = 0;
    while (!if1.done && lat < 20) begin
      if (if1.busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_busy_cycles"}, bc, 2);
    check({tag, "_sum"}, {31'd0, if1.sum}, {31'd0, es});
    check({tag, "_cout"}, {31'd0, if1.cout}, {31'd0, ec});
    @(posedge clk); #1;
    check({tag, "_done_fall"}, {31'd0, if1.done}, 0);
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (!if8.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int done_seen;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] model;

    checks = 0;
    errors = 0;

    v8[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
    v8[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    v8[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    v8[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    v8[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    v8[5] = '{8'h0F, 8'hF0, 8'hFF, 1'b0};
    v8[6] = '{8'h10, 8'h20, 8'h30, 1'b0};
    v8[7] = '{8'h7F, 8'h01, 8'h80, 1'b0};

    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    v1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    v1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

    if8.start = 1'b0; if8.op_a = '0; if8.op_b = '0;
    if1.start = 1'b0; if1.op_a = '0; if1.op_b = '0;
    rst_n = 1'b0;

    #3;
    check("por_busy", {31'd0, if8.busy}, 0);
    check("por_done", {31'd0, if8.done}, 0);
    check("por_sum",  {24'd0, if8.sum}, 0);
    check("por_cout", {31'd0, if8.cout}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors on the W=8 instance.
    for (int i = 0; i < 8; i++) begin
      op8(v8[i].a, v8[i].b, v8[i].s, v8[i].c, $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle with a non-zero result held (0x7F).
    op8(8'h35, 8'h4A, 8'h7F, 1'b0, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, if8.busy}, 0);
    check("arst_done", {31'd0, if8.done}, 0);
    check("arst_sum",  {24'd0, if8.sum}, 0);
    check("arst_cout", {31'd0, if8.cout}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: restart in the DONE cycle, disturb inputs during SHIFT.
    @(negedge clk);
    if8.start = 1'b1; if8.op_a = 8'h35; if8.op_b = 8'h4A;
    @(posedge clk); #1;
    if8.start = 1'b0;
    wait_done8(lat);
    check("b2b_first_latency", lat, 9);
    check("b2b_first_sum", {24'd0, if8.sum}, 32'h7F);
    @(negedge clk);
    if8.start = 1'b1; if8.op_a = 8'h10; if8.op_b = 8'h20;
    @(posedge clk); #1;
    check("b2b_no_gap_busy", {31'd0, if8.busy}, 1);
    check("b2b_no_gap_done", {31'd0, if8.done}, 0);
    if8.op_a = 8'hFF; if8.op_b = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    if8.start = 1'b0;
    wait_done8(lat);
    check("b2b_latency", lat + 3, 9);
    check("b2b_sum",  {24'd0, if8.sum}, 32'h30);
    check("b2b_cout", {31'd0, if8.cout}, 0);
    @(posedge clk); #1;
    check("b2b_done_fall", {31'd0, if8.done}, 0);

    // Reset during SHIFT: outputs clear, no done pulse, then a clean add.
    @(negedge clk);
    if8.start = 1'b1; if8.op_a = 8'hAA; if8.op_b = 8'h55;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, if8.busy}, 0);
    check("midrst_done", {31'd0, if8.done}, 0);
    check("midrst_sum",  {24'd0, if8.sum}, 0);
    check("midrst_cout", {31'd0, if8.cout}, 0);
    done_seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    op8(8'h01, 8'h01, 8'h02, 1'b0, "post_rst");

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      model = {1'b0, ra} + {1'b0, rb};
      op8(ra, rb, model[7:0], model[8], $sformatf("rand%0d", i));
    end

    // W=1 instance, all four operand pairs.
    for (int i = 0; i < 4; i++) begin
      op1(v1[i].a, v1[i].b, v1[i].s, v1[i].c, $sformatf("w1_vec%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
